// File: rtl/phase_sequencer.sv
// Traffic-light phase sequencer.
// Each phase cycles GREEN -> YELLOW -> ALLRED, then hands over to the next
// demanded phase, searching round-robin. enable low forces flashing yellow.
// hold freezes all timing. Every output comes straight from a register.
module phase_sequencer #(
   parameter int unsigned CLK_HZ     = 10000,
   parameter int unsigned NUM_PHASES = 4,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned YELLOW_S   = 3,
   parameter int unsigned ALLRED_S   = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          hold,
   input  logic [NUM_PHASES-1:0]         demand,
   input  logic [NUM_PHASES*CNT_W-1:0]   green_s,
   output logic [2*NUM_PHASES-1:0]       light,
   output logic [$clog2(NUM_PHASES)-1:0] phase,
   output logic [CNT_W-1:0]              remaining,
   output logic                          sec_tick,
   output logic                          finished
);

   localparam int unsigned      PH_W    = $clog2(NUM_PHASES);
   localparam int unsigned      PS_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(CLK_HZ - 1);
   localparam logic [CNT_W-1:0] YEL_DUR = CNT_W'(YELLOW_S);
   localparam logic [CNT_W-1:0] AR_DUR  = CNT_W'(ALLRED_S);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   localparam logic [1:0] S_FLASH  = 2'd0;
   localparam logic [1:0] S_ALLRED = 2'd1;
   localparam logic [1:0] S_GREEN  = 2'd2;
   localparam logic [1:0] S_YELLOW = 2'd3;

   localparam logic [1:0] L_RED   = 2'b00;
   localparam logic [1:0] L_YEL   = 2'b01;
   localparam logic [1:0] L_GRN   = 2'b10;
   localparam logic [1:0] L_FLASH = 2'b11;

   logic [1:0]              state_q,   state_d;
   logic [PH_W-1:0]         phase_q,   phase_d;
   logic [CNT_W-1:0]        rem_q,     rem_d;
   logic [PS_W-1:0]         presc_q,   presc_d;
   logic [NUM_PHASES-1:0]   pending_q, pending_d;
   logic [2*NUM_PHASES-1:0] light_q,   light_d;
   logic                    tick_q,    tick_d;
   logic                    fin_q,     fin_d;

   logic [PH_W-1:0]         next_phase;
   logic [PH_W-1:0]         cand;
   logic                    found;
   logic [CNT_W-1:0]        next_green;
   logic [NUM_PHASES-1:0]   clr;
   logic                    running;

   // Per-phase light code for a given state and active phase.
   function automatic logic [2*NUM_PHASES-1:0] light_code(input logic [1:0]      st,
                                                          input logic [PH_W-1:0] ph);
      logic [2*NUM_PHASES-1:0] l;
      l = '0;
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
         case (st)
            S_FLASH:  l[2*i +: 2] = L_FLASH;
            S_GREEN:  l[2*i +: 2] = (PH_W'(i) == ph) ? L_GRN : L_RED;
            S_YELLOW: l[2*i +: 2] = (PH_W'(i) == ph) ? L_YEL : L_RED;
            default:  l[2*i +: 2] = L_RED;
         endcase
      end
      return l;
   endfunction

   // Round-robin pick of the next pending phase after the current one; repeat current if none.
   always_comb begin
      next_phase = phase_q;
      found      = 1'b0;
      cand       = '0;
      for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
         cand = PH_W'((32'(phase_q) + k) % NUM_PHASES);
         if (!found && pending_q[cand]) begin
            next_phase = cand;
            found      = 1'b1;
         end
      end
   end

   // Green duration of the phase about to be served; zero is stretched to one second.
   always_comb begin
      next_green = '0;
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
         if (PH_W'(i) == next_phase) next_green = green_s[i*CNT_W +: CNT_W];
      end
      if (next_green == '0) next_green = ONE;
   end

   // Next-state logic: flash override, flash exit, then hold-gated prescaler/second timing.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rem_d   = rem_q;
      presc_d = presc_q;
      clr     = '0;

      if (!enable) begin
         state_d = S_FLASH;
         phase_d = '0;
         rem_d   = '0;
         presc_d = '0;
      end else if (state_q == S_FLASH) begin
         state_d = S_ALLRED;
         phase_d = '0;
         rem_d   = AR_DUR;
         presc_d = '0;
      end else if (!hold) begin
         if (presc_q == PS_MAX) begin
            presc_d = '0;
            // Transition on the tick seen with one second left; the <= also stops any wrap below zero.
            if (rem_q > ONE) begin
               rem_d = rem_q - ONE;
            end else begin
               case (state_q)
                  S_GREEN: begin
                     state_d = S_YELLOW;
                     rem_d   = YEL_DUR;
                  end
                  S_YELLOW: begin
                     state_d = S_ALLRED;
                     rem_d   = AR_DUR;
                  end
                  default: begin
                     state_d = S_GREEN;
                     phase_d = next_phase;
                     rem_d   = next_green;
                     for (int unsigned i = 0; i < NUM_PHASES; i++) begin
                        clr[i] = (PH_W'(i) == next_phase);
                     end
                  end
               endcase
            end
         end else begin
            presc_d = presc_q + PS_W'(1);
         end
      end

      // Served phase's request is dropped even if it is re-asserted on the entry edge.
      pending_d = (pending_q | demand) & ~clr;

      // Registered outputs are precomputed from the next state so they line up with it.
      running = enable && ((state_q == S_FLASH) || !hold);
      tick_d  = running && (state_d != S_FLASH) && (presc_d == PS_MAX);
      fin_d   = tick_d && (state_d == S_ALLRED) && (rem_d <= ONE);
      light_d = light_code(state_d, phase_d);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_ALLRED;
         phase_q   <= '0;
         rem_q     <= AR_DUR;
         presc_q   <= '0;
         pending_q <= '0;
         light_q   <= '0;
         tick_q    <= 1'b0;
         fin_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         rem_q     <= rem_d;
         presc_q   <= presc_d;
         pending_q <= pending_d;
         light_q   <= light_d;
         tick_q    <= tick_d;
         fin_q     <= fin_d;
      end
   end

   assign light     = light_q;
   assign phase     = phase_q;
   assign remaining = rem_q;
   assign sec_tick  = tick_q;
   assign finished  = fin_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: CLK_HZ=4, 3 phases, yellow 2 s, all-red 1 s,
// green seconds {2,5,3} for phases 2,1,0.
module tb_phase_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        hold;
   logic [2:0]  demand;
   logic [23:0] green_s;
   logic [5:0]  light;
   logic [1:0]  phase;
   logic [7:0]  remaining;
   logic        sec_tick;
   logic        finished;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   phase_sequencer #(
      .CLK_HZ    (4),
      .NUM_PHASES(3),
      .CNT_W     (8),
      .YELLOW_S  (2),
      .ALLRED_S  (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .hold     (hold),
      .demand   (demand),
      .green_s  (green_s),
      .light    (light),
      .phase    (phase),
      .remaining(remaining),
      .sec_tick (sec_tick),
      .finished (finished)
   );

   typedef struct {
      logic        en;
      logic        hd;
      logic [2:0]  dm;
      int unsigned n;
      logic [5:0]  l;
      logic [1:0]  p;
      logic [7:0]  r;
      logic        t;
      logic        f;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic e, input logic h, input logic [2:0] d,
                               input int unsigned n, input logic [5:0] l, input logic [1:0] p,
                               input logic [7:0] r, input logic t, input logic f);
      vec_t v;
      v.en = e; v.hd = h; v.dm = d; v.n = n;
      v.l = l; v.p = p; v.r = r; v.t = t; v.f = f;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [5:0] l, input logic [1:0] p,
                          input logic [7:0] r, input logic t, input logic f);
      chk({tag, ".light"},     32'(light),     32'(l));
      chk({tag, ".phase"},     32'(phase),     32'(p));
      chk({tag, ".remaining"}, 32'(remaining), 32'(r));
      chk({tag, ".sec_tick"},  32'(sec_tick),  32'(t));
      chk({tag, ".finished"},  32'(finished),  32'(f));
   endtask

   // Hold reset for two cycles, check the reset outputs, release on a falling edge.
   task automatic do_reset(input string tag);
      reset   = 1'b0;
      enable  = 1'b1;
      hold    = 1'b0;
      demand  = 3'b000;
      green_s = {8'd2, 8'd5, 8'd3};
      repeat (2) @(negedge clk);
      chk_out({tag, ".in_reset"}, 6'b000000, 2'd0, 8'd1, 1'b0, 1'b0);
      chk({tag, ".in_reset.pending"}, 32'(dut.pending_q), 32'd0);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      enable  = 1'b1;
      hold    = 1'b0;
      demand  = 3'b000;
      green_s = {8'd2, 8'd5, 8'd3};
      #1 reset = 1'b0;

      // ---- Table: no-demand cycle, then a skip to phase 2 and a repeat of phase 2.
      // Each row drives inputs, advances n rising edges, then checks outputs.
      //              en    hd    dm      n   light      ph  rem  tick  fin
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 0, 6'b000000, 0, 1, 1'b0, 1'b0)); // t0  all red
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 3, 6'b000000, 0, 1, 1'b1, 1'b1)); // t3  last all-red cycle
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 1, 6'b000010, 0, 3, 1'b0, 1'b0)); // t4  phase0 green
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 3, 6'b000010, 0, 3, 1'b1, 1'b0)); // t7  first tick
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 1, 6'b000010, 0, 2, 1'b0, 1'b0)); // t8
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 7, 6'b000010, 0, 1, 1'b1, 1'b0)); // t15 last green
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 1, 6'b000001, 0, 2, 1'b0, 1'b0)); // t16 yellow
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 7, 6'b000001, 0, 1, 1'b1, 1'b0)); // t23 last yellow
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 1, 6'b000000, 0, 1, 1'b0, 1'b0)); // t24 all red
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 3, 6'b000000, 0, 1, 1'b1, 1'b1)); // t27 finished
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 1, 6'b000010, 0, 3, 1'b0, 1'b0)); // t28 phase0 again
      tbl.push_back(mk(1'b1, 1'b0, 3'b100, 1, 6'b000010, 0, 3, 1'b0, 1'b0)); // t29 demand[2] pulse
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 22, 6'b000000, 0, 1, 1'b1, 1'b1)); // t51 all-red end
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 1, 6'b100000, 2, 2, 1'b0, 1'b0)); // t52 phase2 green
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 7, 6'b100000, 2, 1, 1'b1, 1'b0)); // t59 last green
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 1, 6'b010000, 2, 2, 1'b0, 1'b0)); // t60 phase2 yellow
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 11, 6'b000000, 2, 1, 1'b1, 1'b1)); // t71 all-red end
      tbl.push_back(mk(1'b1, 1'b0, 3'b000, 1, 6'b100000, 2, 2, 1'b0, 1'b0)); // t72 phase2 repeats

      do_reset("tbl");
      for (int i = 0; i < tbl.size(); i++) begin
         enable = tbl[i].en;
         hold   = tbl[i].hd;
         demand = tbl[i].dm;
         repeat (tbl[i].n) @(negedge clk);
         chk_out($sformatf("row%0d", i), tbl[i].l, tbl[i].p, tbl[i].r, tbl[i].t, tbl[i].f);
         if (i == 13) chk("skip.pending_cleared", 32'(dut.pending_q), 32'd0);
      end

      // ---- Hold for 10 cycles mid phase0 green: green stretches to 22 cycles.
      do_reset("hold");
      repeat (6) @(negedge clk);                                      // t6: presc=2
      chk_out("hold.before", 6'b000010, 2'd0, 8'd3, 1'b0, 1'b0);
      hold = 1'b1;
      for (int k = 0; k < 10; k++) begin
         demand = (k == 4) ? 3'b010 : 3'b000;
         @(negedge clk);
         chk($sformatf("hold.frozen_rem%0d", k),   32'(remaining), 32'd3);
         chk($sformatf("hold.frozen_tick%0d", k),  32'(sec_tick),  32'd0);
         chk($sformatf("hold.frozen_light%0d", k), 32'(light),     32'h02);
      end
      demand = 3'b000;
      hold   = 1'b0;                                                  // t16
      chk("hold.pending_captured", 32'(dut.pending_q), 32'b010);
      repeat (9) @(negedge clk);                                      // t25
      chk_out("hold.last_green", 6'b000010, 2'd0, 8'd1, 1'b1, 1'b0);
      @(negedge clk);                                                 // t26
      chk_out("hold.yellow", 6'b000001, 2'd0, 8'd2, 1'b0, 1'b0);

      // ---- Flash mid-yellow, then recover into phase1 whose green is set to 0 s.
      @(negedge clk);                                                 // t27
      enable = 1'b0;
      green_s[15:8] = 8'd0;
      @(negedge clk);                                                 // t28
      chk_out("flash.entry", 6'b111111, 2'd0, 8'd0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk_out($sformatf("flash.stay%0d", k), 6'b111111, 2'd0, 8'd0, 1'b0, 1'b0);
      end
      chk("flash.pending_kept", 32'(dut.pending_q), 32'b010);
      enable = 1'b1;                                                  // t30
      @(negedge clk);                                                 // t31
      chk_out("flash.exit", 6'b000000, 2'd0, 8'd1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);                                      // t34
      chk("flash.allred_last.light", 32'(light), 32'd0);
      chk("flash.allred_last.tick",  32'(sec_tick), 32'd1);
      @(negedge clk);                                                 // t35
      chk_out("zero.green_entry", 6'b001000, 2'd1, 8'd1, 1'b0, 1'b0);
      chk("zero.pending_cleared", 32'(dut.pending_q), 32'd0);
      repeat (3) @(negedge clk);                                      // t38
      chk_out("zero.green_last", 6'b001000, 2'd1, 8'd1, 1'b1, 1'b0);
      @(negedge clk);                                                 // t39
      chk_out("zero.yellow", 6'b000100, 2'd1, 8'd2, 1'b0, 1'b0);

      // ---- Asynchronous reset mid-green, then release with enable low.
      do_reset("async");
      repeat (5) @(negedge clk);                                      // t5 phase0 green
      chk_out("async.green", 6'b000010, 2'd0, 8'd3, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk_out("async.immediate", 6'b000000, 2'd0, 8'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("async.held", 6'b000000, 2'd0, 8'd1, 1'b0, 1'b0);
      enable = 1'b0;
      reset  = 1'b1;
      @(negedge clk);
      chk_out("async.to_flash", 6'b111111, 2'd0, 8'd0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
